// File: rtl/div_pkg.sv
// Shared types and widths for the 8-by-4 restoring divider.
package div_pkg;

    localparam int unsigned DVD_W    = 8;
    localparam int unsigned DVS_W    = 4;
    localparam int unsigned DIV_ITER = 8;
    localparam int unsigned CNT_W    = $clog2(DIV_ITER);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_LATCH = 2'd1,
        ST_CALC  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/divider_8by4_if.sv
// trig/done handshake plus operand and result bus of the divider.
// div_by_zero exists only when DIV_ZERO_DETECT_EN is defined.
interface divider_8by4_if;
    import div_pkg::*;

    logic             trig;
    logic [DVD_W-1:0] dividend;
    logic [DVS_W-1:0] divisor;
    logic             done;
    logic [DVD_W-1:0] quotient;
    logic [DVS_W-1:0] remainder;
`ifdef DIV_ZERO_DETECT_EN
    logic             div_by_zero;
`endif

    modport master (
        output trig, dividend, divisor,
`ifdef DIV_ZERO_DETECT_EN
        input  div_by_zero,
`endif
        input  done, quotient, remainder
    );

    modport slave (
        input  trig, dividend, divisor,
`ifdef DIV_ZERO_DETECT_EN
        output div_by_zero,
`endif
        output done, quotient, remainder
    );

endinterface

// File: rtl/div_state_machine.sv
// INIT/LATCH/CALC/DONE controller for the divider; DIV_ZERO_DETECT_EN adds
// the LATCH->DONE shortcut for a zero divisor.
module div_state_machine
    import div_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             trig,
    input  logic [CNT_W-1:0] count,
`ifdef DIV_ZERO_DETECT_EN
    input  logic             dvs_zero,
`endif
    output state_t           state,
    output state_t           state_next_c
);

    always_ff @(posedge clk) begin
        if (!rst) state <= ST_INIT;
        else      state <= state_next_c;
    end

    always_comb begin
        state_next_c = state;
        unique case (state)
            ST_INIT:  if (trig) state_next_c = ST_LATCH;
`ifdef DIV_ZERO_DETECT_EN
            ST_LATCH: state_next_c = dvs_zero ? ST_DONE : ST_CALC;
`else
            ST_LATCH: state_next_c = ST_CALC;
`endif
            ST_CALC:  if (count == '0) state_next_c = ST_DONE;
            // Holding trig high in DONE must not retrigger.
            ST_DONE:  if (!trig) state_next_c = ST_INIT;
            default:  state_next_c = ST_INIT;
        endcase
    end

endmodule

// File: rtl/divider_8by4.sv
// Sequential restoring divider, 8-bit dividend / 4-bit divisor, one quotient
// bit per clock. Optional zero-divisor detection via DIV_ZERO_DETECT_EN.
module divider_8by4
    import div_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    divider_8by4_if.slave  bus
);

    state_t           state;
    state_t           state_next_c;
    logic [CNT_W-1:0] count;
    logic [DVS_W-1:0] dvs;
    logic [DVD_W-1:0] quo;
    logic [DVS_W-1:0] rem;
    logic             done_q;

    logic [DVS_W:0]   trial_c;
    logic [DVS_W-1:0] rem_sub_c;
    logic             borrow_c;

`ifdef DIV_ZERO_DETECT_EN
    logic dvs_zero_c;
    logic div_by_zero_q;
    assign dvs_zero_c      = (bus.divisor == '0);
    assign bus.div_by_zero = div_by_zero_q;
`endif

    div_state_machine u_sm (
        .clk          (clk),
        .rst          (rst),
        .trig         (bus.trig),
        .count        (count),
`ifdef DIV_ZERO_DETECT_EN
        .dvs_zero     (dvs_zero_c),
`endif
        .state        (state),
        .state_next_c (state_next_c)
    );

    // Shift in the next dividend bit and try to subtract the divisor.
    assign trial_c   = {rem, quo[DVD_W-1]};
    assign rem_sub_c = trial_c[DVS_W-1:0] - dvs;
    assign borrow_c  = (trial_c < {1'b0, dvs});

    always_ff @(posedge clk) begin
        if (!rst) begin
            count  <= '0;
            dvs    <= '0;
            quo    <= '0;
            rem    <= '0;
            done_q <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
            div_by_zero_q <= 1'b0;
`endif
        end else begin
            done_q <= (state_next_c == ST_DONE);
            unique case (state)
                ST_LATCH: begin
                    dvs   <= bus.divisor;
                    quo   <= bus.dividend;
                    rem   <= '0;
                    count <= CNT_W'(DIV_ITER - 1);
`ifdef DIV_ZERO_DETECT_EN
                    div_by_zero_q <= dvs_zero_c;
                    // Same result the undetected iteration would produce.
                    if (dvs_zero_c) begin
                        quo <= '1;
                        rem <= bus.dividend[DVS_W-1:0];
                    end
`endif
                end
                ST_CALC: begin
                    rem   <= borrow_c ? trial_c[DVS_W-1:0] : rem_sub_c;
                    quo   <= {quo[DVD_W-2:0], ~borrow_c};
                    count <= count - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.done      = done_q;
    assign bus.quotient  = quo;
    assign bus.remainder = rem;

endmodule

// File: tb/tb_divider_8by4.sv
// Directed self-checking bench for divider_8by4 (default and DIV_ZERO_DETECT_EN builds).
module tb_divider_8by4;
    import div_pkg::*;

`ifdef DIV_ZERO_DETECT_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 9;
`endif

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    divider_8by4_if bus ();

    divider_8by4 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present operands with trig high for exactly one edge (edge k); returns just after k.
    task automatic start_op(input logic [7:0] a, input logic [3:0] b);
        @(negedge clk);
        bus.dividend = a;
        bus.divisor  = b;
        bus.trig     = 1'b1;
        @(posedge clk);
        #1;
        bus.trig = 1'b0;
    endtask

    // Edges after k until done is seen, bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [3:0] b,
                          input int exp_n, input logic [7:0] exp_q, input logic [3:0] exp_r,
                          input bit go_idle);
        int n;
        start_op(a, b);
        wait_done(n);
        check({tag, "_lat"}, 32'(n), 32'(exp_n));
        check({tag, "_q"}, 32'(bus.quotient), 32'(exp_q));
        check({tag, "_r"}, 32'(bus.remainder), 32'(exp_r));
        if (go_idle) begin
            @(posedge clk);
            #1;
            check({tag, "_idle_done"}, 32'(bus.done), 32'd0);
            check({tag, "_idle_st"}, 32'(dut.state), 32'(ST_INIT));
            check({tag, "_idle_q"}, 32'(bus.quotient), 32'(exp_q));
            check({tag, "_idle_r"}, 32'(bus.remainder), 32'(exp_r));
        end
    endtask

    initial begin
        rst          = 1'b0;
        bus.trig     = 1'b0;
        bus.dividend = 8'd0;
        bus.divisor  = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_q", 32'(bus.quotient), 32'd0);
        check("rst_r", 32'(bus.remainder), 32'd0);
        check("rst_st", 32'(dut.state), 32'(ST_INIT));
`ifdef DIV_ZERO_DETECT_EN
        check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
`endif
        rst = 1'b1;

        run_op("d100_7", 8'd100, 4'd7, 9, 8'd14, 4'd2, 1'b1);
`ifdef DIV_ZERO_DETECT_EN
        check("d100_7_dbz", 32'(bus.div_by_zero), 32'd0);
`endif
        run_op("d255_1", 8'd255, 4'd1, 9, 8'd255, 4'd0, 1'b1);
        run_op("d5_9", 8'd5, 4'd9, 9, 8'd0, 4'd5, 1'b1);

        // Hold trig through DONE and wiggle operands: result must not move.
        run_op("d255_15", 8'd255, 4'd15, 9, 8'd17, 4'd0, 1'b0);
        @(negedge clk);
        bus.trig     = 1'b1;
        bus.dividend = 8'h33;
        bus.divisor  = 4'h5;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold_done", 32'(bus.done), 32'd1);
            check("hold_q", 32'(bus.quotient), 32'd17);
            check("hold_r", 32'(bus.remainder), 32'd0);
        end
        @(negedge clk);
        bus.trig = 1'b0;
        @(posedge clk);
        #1;
        check("hold_exit_done", 32'(bus.done), 32'd0);
        check("hold_exit_st", 32'(dut.state), 32'(ST_INIT));
        run_op("d64_8", 8'd64, 4'd8, 9, 8'd8, 4'd0, 1'b1);

        run_op("dA7_0", 8'hA7, 4'd0, ZERO_LAT, 8'hFF, 4'h7, 1'b1);
`ifdef DIV_ZERO_DETECT_EN
        check("dA7_0_dbz", 32'(bus.div_by_zero), 32'd1);
`endif

        // Abort 200/3 with reset on the 4th CALC edge (k+5).
        start_op(8'd200, 4'd3);
        repeat (4) @(posedge clk);
        #1;
        check("abort_pre_done", 32'(bus.done), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_q", 32'(bus.quotient), 32'd0);
        check("abort_r", 32'(bus.remainder), 32'd0);
        check("abort_st", 32'(dut.state), 32'(ST_INIT));
`ifdef DIV_ZERO_DETECT_EN
        check("abort_dbz", 32'(bus.div_by_zero), 32'd0);
`endif
        run_op("d9_2", 8'd9, 4'd2, 9, 8'd4, 4'd1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/divider_8by4.md
Name: divider_8by4

Overview:
- Sequential restoring shift-subtract divider: 8-bit unsigned dividend / 4-bit unsigned divisor -> 8-bit quotient, 4-bit remainder.
- Inverse-operation companion to the team's sequential shift-add multiplier; uses the same trig/done handshake and the same INIT/LATCH/CALC/DONE control style.
- Performs one quotient bit per clock.

Parameters:
- None. Widths are fixed: dividend 8, divisor 4, quotient 8, remainder 4, iteration count 8.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset: synchronous, active-low.
- trig  input  1  start request; sampled only in INIT (and in DONE for the return to INIT).
- dividend  input  8  dividend; sampled in LATCH only.
- divisor  input  4  divisor; sampled in LATCH only.
- done  output  1  high exactly while state==DONE.
- quotient  output  8  registered quotient.
- remainder  output  4  registered remainder.
- div_by_zero  output  1  present only with DIV_ZERO_DETECT_EN.

Behaviour:
- Reset (rst==0 at posedge, any state, including mid-CALC): state<=INIT, count<=0, all datapath registers<=0. Result: done=0, quotient=0, remainder=0 (and div_by_zero=0 when compiled in). An aborted operation leaves no residue.
- State machine, 2-bit encoding:
  - INIT: if trig, go to LATCH; else stay.
  - LATCH: one cycle, then CALC.
  - CALC: go to DONE when count==0; else stay.
  - DONE: if trig==0, go to INIT; else stay (trig held high does not retrigger).
- Registers:
  - dvs[3:0]: latched divisor.
  - quo[7:0]: holds the dividend, then becomes the quotient as bits shift in.
  - rem[3:0]: partial remainder.
  - count[2:0].
- LATCH: dvs<=divisor, quo<=dividend, rem<=0, count<=7.
- CALC, each cycle:
  - t = {rem, quo[7]} (5 bits); d = t - {1'b0, dvs} (5-bit, borrow = t<dvs).
  - No borrow: rem<=d[3:0], quo<={quo[6:0],1}.
  - Borrow: rem<=t[3:0], quo<={quo[6:0],0}.
  - count<=count-1.
- Invariant: rem<dvs after every CALC cycle when dvs!=0, so 4 bits suffice.
- Outputs: quotient=quo, remainder=rem, held stable in INIT and DONE until the next LATCH. Values are valid only while done=1 or afterwards, until the next LATCH.
- Latency: if edge k samples trig=1 in INIT, then LATCH at k+1, CALC iterations at edges k+2..k+9, done=1 from edge k+9. Total 10 cycles, fixed for every operand.
- Divisor==0, without the optional feature: no special case. Subtraction never borrows, giving quotient=8'hFF and remainder=dividend[3:0] after the full 8 CALC cycles.
- Operand inputs changing outside LATCH have no effect.

Optional Feature:
- Macro: DIV_ZERO_DETECT_EN.
- Defined:
  - Adds port div_by_zero, registered, set in LATCH to (divisor==0) and cleared by reset.
  - A zero divisor makes LATCH go directly to DONE, skipping CALC (latency 2 cycles).
  - Outputs are forced to quotient=8'hFF, remainder=dividend[3:0], identical to the undetected values.
  - div_by_zero holds with the result until the next LATCH.
- Undefined: no port; divisor 0 runs 8 CALC cycles as described above.

Decomposition:
- Shared package div_pkg:
  - State encodings ST_INIT=2'd0, ST_LATCH=2'd1, ST_CALC=2'd2, ST_DONE=2'd3.
  - DIV_ITER=8.
  - Width constants DVD_W=8, DVS_W=4.
- Sub-module div_state_machine (clk, rst, trig, count, [zero flag], state): owns the next-state logic. The datapath stays in divider_8by4.

Test Plan:
- dividend=100, divisor=7, trig pulse -> done at edge k+9; quotient=14, remainder=2; outputs stable while trig low; state returns to INIT.
- 255/1 -> quotient=255, remainder=0. 5/9 -> quotient=0, remainder=5. 255/15 -> quotient=17, remainder=0.
- dividend=8'hA7, divisor=0:
  - Without the macro: done after 10 cycles, quotient=8'hFF, remainder=4'h7.
  - With the macro: done after 2 cycles, same values, div_by_zero=1.
- Start 200/3, assert rst=0 at the 4th CALC cycle for one edge -> done=0, quotient=0, remainder=0, state INIT. A following 9/2 yields quotient=4, remainder=1.
- Hold trig=1 through DONE for 5 cycles -> done stays 1 with no restart. Change the dividend/divisor inputs meanwhile -> outputs unchanged. Drop trig, then retrigger with 64/8 -> quotient=8, remainder=0.
